// File: rtl/led_drv_pkg.sv
// Shared constants for the LED PWM/blink driver: register map and reset values.
package led_drv_pkg;

  localparam logic [1:0] ADDR_BRIGHT = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // Brightness code that means "always on" rather than a compare threshold
  localparam int BRIGHT_FULL = 255;

  localparam int   RST_BRIGHT = 255;
  localparam int   RST_MASK   = 0;
  localparam int   RST_PERIOD = 0;
  localparam logic RST_PHASE  = 1'b1;

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: prescaler dividing clk into PWM steps, and the free-running PWM counter.
module led_pwm_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 196
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                step,
  output logic                frame_end
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [15:0] prescale_cnt;

  assign step      = (prescale_cnt == PS_LAST);
  assign frame_end = step & (pwm_cnt == {PWM_BITS{1'b1}});

  // Prescaler counts 0..PRESCALE-1 and wraps; PRESCALE=1 keeps it at 0 so step is constant 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     prescale_cnt <= 16'd0;
    else if (step) prescale_cnt <= 16'd0;
    else           prescale_cnt <= prescale_cnt + 16'd1;
  end

  // PWM counter advances once per step and wraps naturally at its width
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pwm_cnt <= '0;
    else if (step) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

endmodule

// File: rtl/led_pwm_blink_driver.sv
// LED pin driver: global PWM dimming plus per-LED blink gating, configured over Avalon-MM.
import led_drv_pkg::*;

module led_pwm_blink_driver #(
  parameter int NUM_LEDS = 10,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 196
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] led_out
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                step;
  logic                frame_end;

  logic [PWM_BITS-1:0] brightness;
  logic [NUM_LEDS-1:0] blink_mask;
  logic [15:0]         blink_period;
  logic [15:0]         blink_cnt;
  logic                blink_phase;

  logic wr_en;
  logic period_wr;
  logic pwm_on;
  logic unused_ok;

  led_pwm_timebase #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk       (clk),
    .reset     (reset),
    .pwm_cnt   (pwm_cnt),
    .step      (step),
    .frame_end (frame_end)
  );

  assign wr_en     = chipselect & ~write_n;
  assign period_wr = wr_en & (address == ADDR_PERIOD);

  // Full-scale code bypasses the compare so 255 is truly always on, not 255/256
  assign pwm_on = (brightness == PWM_BITS'(BRIGHT_FULL)) | (pwm_cnt < brightness);

  // Upper write-data bits and the raw step are intentionally not consumed here
  assign unused_ok = ^{writedata[31:16], step};

  // Writable configuration registers; STATUS address falls through and is ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brightness   <= PWM_BITS'(RST_BRIGHT);
      blink_mask   <= NUM_LEDS'(RST_MASK);
      blink_period <= 16'(RST_PERIOD);
    end else if (wr_en) begin
      case (address)
        ADDR_BRIGHT: brightness   <= writedata[PWM_BITS-1:0];
        ADDR_MASK:   blink_mask   <= writedata[NUM_LEDS-1:0];
        ADDR_PERIOD: blink_period <= writedata[15:0];
        default:     ;
      endcase
    end
  end

  // Blink half-period counter in PWM frames; a period write restarts the cycle and wins over frame_end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= 16'd0;
      blink_phase <= RST_PHASE;
    end else if (period_wr) begin
      blink_cnt   <= 16'd0;
      blink_phase <= 1'b1;
    end else if (frame_end && (blink_period != 16'd0)) begin
      if (blink_cnt == blink_period - 16'd1) begin
        blink_cnt   <= 16'd0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  // Registered pin drive so the outputs never glitch on combinational paths
  always_ff @(posedge clk or posedge reset) begin
    if (reset) led_out <= '0;
    else       led_out <= led_in & {NUM_LEDS{pwm_on}} & (~blink_mask | {NUM_LEDS{blink_phase}});
  end

  // Zero-wait-state read mux, zero-extended
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_BRIGHT: readdata[PWM_BITS-1:0] = brightness;
      ADDR_MASK:   readdata[NUM_LEDS-1:0] = blink_mask;
      ADDR_PERIOD: readdata[15:0]         = blink_period;
      ADDR_STATUS: begin
        readdata[15:8] = 8'(pwm_cnt);
        readdata[0]    = blink_phase;
      end
      default:     readdata = 32'd0;
    endcase
  end

endmodule
